// File: rtl/imem_port_arbiter.sv
//==============================================================================
// imem_port_arbiter : round-robin sharing of the instruction memory read port
// between fetch (IF) and load (LD); optional counters via IMEM_ARB_PERF_EN
// Revision: 1.0
//==============================================================================
`default_nettype none

module imem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              ld_rvalid,
  output logic [DATA_W-1:0] ld_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef IMEM_ARB_PERF_EN
  ,
  output logic [31:0]       perf_if_grants,
  output logic [31:0]       perf_ld_grants,
  output logic [31:0]       perf_conflicts
`endif
);

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_LD = 1'b1;

  logic               last_grant;
  logic [ADDR_W-1:0]  hold_addr;
  logic [MEM_LAT-1:0] pipe_vld;
  logic [MEM_LAT-1:0] pipe_own;
  logic               grant_if;
  logic               grant_ld;
  logic               push_vld;
  logic               tail_vld;
  logic               tail_own;

  // Both valid: the requester that did not win last time gets the port.
  always_comb begin
    grant_if = rst_n & if_valid & (~ld_valid | (last_grant == OWN_LD));
    grant_ld = rst_n & ld_valid & (~if_valid | (last_grant == OWN_IF));
  end

  assign if_ready = grant_if;
  assign ld_ready = grant_ld;
  assign mem_addr = grant_if ? if_addr : (grant_ld ? ld_addr : hold_addr);

  // A fetch granted in a flush cycle is already dead, so it never enters the pipe.
  assign push_vld = grant_ld | (grant_if & ~if_flush);
  assign tail_vld = pipe_vld[MEM_LAT-1];
  assign tail_own = pipe_own[MEM_LAT-1];

  assign if_rvalid = rst_n & tail_vld & (tail_own == OWN_IF) & ~if_flush;
  assign ld_rvalid = rst_n & tail_vld & (tail_own == OWN_LD);
  assign if_rdata  = mem_rdata;
  assign ld_rdata  = mem_rdata;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant <= OWN_IF;
      hold_addr  <= '0;
      pipe_vld   <= '0;
      pipe_own   <= '0;
    end else begin
      if (grant_if | grant_ld) begin
        last_grant <= grant_ld ? OWN_LD : OWN_IF;
      end
      hold_addr   <= mem_addr;
      pipe_vld[0] <= push_vld;
      pipe_own[0] <= grant_ld;
      for (int i = MEM_LAT - 1; i >= 1; i--) begin
        pipe_vld[i] <= pipe_vld[i-1] & ~(if_flush & (pipe_own[i-1] == OWN_IF));
        pipe_own[i] <= pipe_own[i-1];
      end
    end
  end

`ifdef IMEM_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_if_grants <= '0;
      perf_ld_grants <= '0;
      perf_conflicts <= '0;
    end else begin
      if (grant_if)             perf_if_grants <= perf_if_grants + 32'd1;
      if (grant_ld)             perf_ld_grants <= perf_ld_grants + 32'd1;
      if (if_valid && ld_valid) perf_conflicts <= perf_conflicts + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_imem_port_arbiter.sv
//==============================================================================
// tb_imem_port_arbiter : table-driven bench for imem_port_arbiter (MEM_LAT=2)
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_imem_port_arbiter;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid, if_flush, ld_valid;
  logic [31:0] if_addr, ld_addr;
  logic        if_ready, ld_ready, if_rvalid, ld_rvalid;
  logic [31:0] if_rdata, ld_rdata, mem_addr, mem_rdata;
`ifdef IMEM_ARB_PERF_EN
  logic [31:0] perf_if_grants, perf_ld_grants, perf_conflicts;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  imem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_valid(if_valid), .if_ready(if_ready), .if_addr(if_addr), .if_flush(if_flush),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr),
    .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata)
`ifdef IMEM_ARB_PERF_EN
    , .perf_if_grants(perf_if_grants), .perf_ld_grants(perf_ld_grants),
    .perf_conflicts(perf_conflicts)
`endif
  );

  // Memory model: word is a fixed function of the address seen LAT cycles earlier.
  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
  endfunction

  logic [31:0] addr_d [LAT];
  always @(posedge clk) begin
    addr_d[0] <= mem_addr;
    for (int i = 1; i < LAT; i++) addr_d[i] <= addr_d[i-1];
  end
  assign mem_rdata = word_of(addr_d[LAT-1]);

  typedef struct {
    logic        rst;
    logic        ifv;
    logic [31:0] ifa;
    logic        fl;
    logic        ldv;
    logic [31:0] lda;
    logic        ifr;
    logic        ldr;
    logic [31:0] ma;
    logic        ifrv;
    logic        ldrv;
    logic [31:0] ra;
  } vec_t;

  vec_t tv[$];

  task automatic v(input logic rst, input logic ifv, input logic [31:0] ifa,
                   input logic fl, input logic ldv, input logic [31:0] lda,
                   input logic ifr, input logic ldr, input logic [31:0] ma,
                   input logic ifrv, input logic ldrv, input logic [31:0] ra);
    vec_t e;
    e.rst = rst; e.ifv = ifv; e.ifa = ifa; e.fl = fl; e.ldv = ldv; e.lda = lda;
    e.ifr = ifr; e.ldr = ldr; e.ma = ma; e.ifrv = ifrv; e.ldrv = ldrv; e.ra = ra;
    tv.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic ifv, input logic [31:0] ifa,
                       input logic fl, input logic ldv, input logic [31:0] lda);
    rst_n = rst; if_valid = ifv; if_addr = ifa; if_flush = fl;
    ld_valid = ldv; ld_addr = lda;
  endtask

  initial begin
    drive(1'b0, 1'b1, 32'h44, 1'b0, 1'b1, 32'h44);

    // Normal traffic, conflicts, flushes, hold, then reset mid-flight.
    v(1,0,32'h0,0,0,32'h0,     0,0,32'h0,   0,0,32'h0);
    v(1,1,32'h0,0,0,32'h0,     1,0,32'h0,   0,0,32'h0);
    v(1,1,32'h4,0,0,32'h0,     1,0,32'h4,   0,0,32'h0);
    v(1,1,32'h8,0,0,32'h0,     1,0,32'h8,   1,0,32'h0);
    v(1,0,32'h0,0,0,32'h0,     0,0,32'h8,   1,0,32'h4);
    v(1,0,32'h0,0,0,32'h0,     0,0,32'h8,   1,0,32'h8);
    v(1,0,32'h0,0,0,32'h0,     0,0,32'h8,   0,0,32'h0);
    v(1,1,32'h100,0,1,32'h200, 0,1,32'h200, 0,0,32'h0);
    v(1,1,32'h100,0,1,32'h204, 1,0,32'h100, 0,0,32'h0);
    v(1,1,32'h104,0,1,32'h204, 0,1,32'h204, 0,1,32'h200);
    v(1,1,32'h104,0,1,32'h208, 1,0,32'h104, 1,0,32'h100);
    v(1,0,32'h0,0,0,32'h0,     0,0,32'h104, 0,1,32'h204);
    v(1,0,32'h0,0,0,32'h0,     0,0,32'h104, 1,0,32'h104);
    v(1,1,32'h10,0,1,32'h300,  0,1,32'h300, 0,0,32'h0);
    v(1,1,32'h10,0,0,32'h0,    1,0,32'h10,  0,0,32'h0);
    v(1,1,32'h14,1,0,32'h0,    1,0,32'h14,  0,1,32'h300);
    v(1,0,32'h0,0,0,32'h0,     0,0,32'h14,  0,0,32'h0);
    v(1,0,32'h0,0,0,32'h0,     0,0,32'h14,  0,0,32'h0);
    v(1,1,32'h20,0,0,32'h0,    1,0,32'h20,  0,0,32'h0);
    v(1,0,32'h0,0,0,32'h0,     0,0,32'h20,  0,0,32'h0);
    v(1,0,32'h0,1,0,32'h0,     0,0,32'h20,  0,0,32'h0);
    v(1,1,32'h24,0,0,32'h0,    1,0,32'h24,  0,0,32'h0);
    v(1,0,32'h0,0,0,32'h0,     0,0,32'h24,  0,0,32'h0);
    v(1,0,32'h0,0,0,32'h0,     0,0,32'h24,  1,0,32'h24);
    v(1,1,32'h40,0,1,32'h400,  0,1,32'h400, 0,0,32'h0);
    v(1,1,32'h40,0,0,32'h0,    1,0,32'h40,  0,0,32'h0);
    v(1,0,32'h0,0,0,32'h0,     0,0,32'h40,  0,1,32'h400);
    v(1,0,32'h0,0,0,32'h0,     0,0,32'h40,  1,0,32'h40);
    v(1,0,32'h0,0,1,32'h500,   0,1,32'h500, 0,0,32'h0);
    v(1,0,32'h0,0,1,32'h504,   0,1,32'h504, 0,0,32'h0);
    v(1,0,32'h0,0,0,32'h0,     0,0,32'h504, 0,1,32'h500);
    v(1,0,32'h0,0,0,32'h0,     0,0,32'h504, 0,1,32'h504);
    v(1,1,32'h60,0,1,32'h600,  1,0,32'h60,  0,0,32'h0);
    v(1,0,32'h0,0,1,32'h600,   0,1,32'h600, 0,0,32'h0);
    v(1,0,32'h0,0,0,32'h0,     0,0,32'h600, 1,0,32'h60);
    v(1,0,32'h0,0,0,32'h0,     0,0,32'h600, 0,1,32'h600);
    v(1,1,32'h80,0,0,32'h0,    1,0,32'h80,  0,0,32'h0);
    v(1,0,32'h0,0,1,32'h800,   0,1,32'h800, 0,0,32'h0);
    v(0,1,32'h84,0,1,32'h804,  0,0,32'h800, 0,0,32'h0);
    v(1,0,32'h0,0,0,32'h0,     0,0,32'h0,   0,0,32'h0);
    v(1,1,32'h0,0,0,32'h0,     1,0,32'h0,   0,0,32'h0);
    v(1,0,32'h0,0,0,32'h0,     0,0,32'h0,   0,0,32'h0);
    v(1,0,32'h0,0,0,32'h0,     0,0,32'h0,   1,0,32'h0);

    // Power-on reset held for two cycles with requests pending.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_if_ready",  {31'd0, if_ready},  32'd0);
    chk("rst_ld_ready",  {31'd0, ld_ready},  32'd0);
    chk("rst_if_rvalid", {31'd0, if_rvalid}, 32'd0);
    chk("rst_ld_rvalid", {31'd0, ld_rvalid}, 32'd0);
    chk("rst_mem_addr",  mem_addr,           32'h0);

    for (int k = 0; k < tv.size(); k++) begin
      @(posedge clk);
      #1;
      drive(tv[k].rst, tv[k].ifv, tv[k].ifa, tv[k].fl, tv[k].ldv, tv[k].lda);
      @(negedge clk);
      chk($sformatf("v%0d_if_ready", k),  {31'd0, if_ready},  {31'd0, tv[k].ifr});
      chk($sformatf("v%0d_ld_ready", k),  {31'd0, ld_ready},  {31'd0, tv[k].ldr});
      chk($sformatf("v%0d_mem_addr", k),  mem_addr,           tv[k].ma);
      chk($sformatf("v%0d_if_rvalid", k), {31'd0, if_rvalid}, {31'd0, tv[k].ifrv});
      chk($sformatf("v%0d_ld_rvalid", k), {31'd0, ld_rvalid}, {31'd0, tv[k].ldrv});
      if (tv[k].ifrv) chk($sformatf("v%0d_if_rdata", k), if_rdata, word_of(tv[k].ra));
      if (tv[k].ldrv) chk($sformatf("v%0d_ld_rdata", k), ld_rdata, word_of(tv[k].ra));
    end

`ifdef IMEM_ARB_PERF_EN
    // 5 IF-only grants, then 3 conflicts granted LD, IF, LD.
    @(posedge clk); #1; drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(posedge clk); #1; drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk("perf_if_rst",  perf_if_grants, 32'd0);
    chk("perf_ld_rst",  perf_ld_grants, 32'd0);
    chk("perf_cf_rst",  perf_conflicts, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1; drive(1'b1, 1'b1, 32'(i * 4), 1'b0, 1'b0, 32'h0);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1; drive(1'b1, 1'b1, 32'h100, 1'b0, 1'b1, 32'h200);
    end
    @(posedge clk); #1; drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk("perf_if_grants", perf_if_grants, 32'd6);
    chk("perf_ld_grants", perf_ld_grants, 32'd2);
    chk("perf_conflicts", perf_conflicts, 32'd3);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
